regfile_pipelined: RTL and testbench
====================================

Name: regfile_pipelined

Overview:
- Parametrised, pipelined successor to the single-cycle register file for the RISC-V datapath.
- Two registered read ports and one write port, with same-cycle write-to-read bypass.
- Hardwired zero register (optional) and synchronous clear.
- Integrated per-register pending-write scoreboard, so the decode stage can detect RAW hazards against in-flight producers.

Parameters:
DATA_W, 32, width of each register in bits
ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers
ZERO_REG, 1, 1 = register 0 reads as 0 and ignores writes/claims; 0 = register 0 is ordinary

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high reset
readEn  input  1  capture read addresses this cycle
readReg1  input  ADDR_W  read port 1 address
readReg2  input  ADDR_W  read port 2 address
readData1  output  DATA_W  registered read data, port 1
readData2  output  DATA_W  registered read data, port 2
readValid  output  1  high for exactly one cycle, the cycle after readEn
busy1  output  1  registered pending status of readReg1, captured with readData1
busy2  output  1  registered pending status of readReg2, captured with readData2
regWrite  input  1  write enable
writeReg  input  ADDR_W  write address
writeData  input  DATA_W  write data
claimEn  input  1  mark claimReg as having an in-flight producer
claimReg  input  ADDR_W  register being claimed
pendingMask  output  DEPTH  current scoreboard bits, bit i = register i pending

Behaviour:
- Clock port is clk; reset port is reset. There is one clock, and reset is synchronous and active-high.
- Reset (posedge clk with reset=1):
  - All DEPTH registers become 0 and pendingMask becomes 0.
  - readData1/2, busy1/2 and readValid become 0.
  - Reset dominates every other input in that cycle, including a same-cycle write, claim or read.
- Write:
  - At posedge with regWrite=1, the register array entry writeReg takes writeData.
  - The same edge clears pendingMask[writeReg].
- Read latency is 1 cycle:
  - At posedge with readEn=1, readDataN and busyN are loaded, and readValid is set to 1 for the following cycle.
  - With readEn=0, readDataN and busyN hold their previous values and readValid=0.
- Bypass (write-first): if regWrite=1 and writeReg==readRegN on the same edge as readEn, readDataN = writeData, not the old array value.
- busyN value:
  - busyN = pendingMask[readRegN] as it stands after the same-cycle write clear is applied.
  - It does not include a same-cycle claim, because the consumer issued earlier than that claim.
- Scoreboard:
  - At posedge with claimEn=1, pendingMask[claimReg] is set.
  - Claim and write to the same register on the same edge: the bit ends 1 (the new producer wins). The data is still written.
  - Claim of an already-pending register: the bit stays 1. There is no counting; the pipeline guarantees one producer per register at a time.
  - A write to a non-pending register is legal. The data is written and the bit stays 0.
- Zero register (ZERO_REG=1):
  - Writes to address 0 are dropped and claims to address 0 are dropped.
  - Reads of address 0 return 0 with busy=0, including under bypass.
  - pendingMask[0] is constantly 0.
- ZERO_REG=0: address 0 is treated like every other register.
- Both read ports may address the same register, including under bypass. Both ports return identical data.
- No combinational path from any input to any output. Every output comes from a flop.
- Simulation: no #delays and no initial blocks. Contents are defined only after the first reset.

Test Plan:
- Reset, then readEn with readReg1=3, readReg2=7 -> next cycle readValid=1, readData1=readData2=0, busy1=busy2=0, pendingMask=0.
- Write x5=32'hDEADBEEF in cycle N; readEn readReg1=5 in cycle N+1 -> readData1=32'hDEADBEEF at N+2, readValid high only in N+2.
- Bypass: same cycle regWrite writeReg=9 writeData=32'h1234 and readEn readReg1=9, readReg2=9 -> next cycle both readData1 and readData2 = 32'h1234.
- ZERO_REG=1:
  - regWrite x0=32'hFFFFFFFF with claimEn claimReg=0, then read x0 -> readData1=0, busy1=0, pendingMask[0]=0.
  - Repeat with ZERO_REG=0 -> readData1=32'hFFFFFFFF.
- Scoreboard sequence:
  - Claim x4 -> pendingMask[4]=1; then readEn readReg2=4 -> busy2=1.
  - Then regWrite x4 and readEn readReg2=4 on the same edge -> busy2=0 and the bit clears.
  - Then claim and write x4 on the same edge -> pendingMask[4]=1 and x4 holds the new data.
- Reset mid-operation: with pending bits set and nonzero registers, assert reset together with regWrite/claimEn/readEn -> all registers and pendingMask are 0, readValid=0 next cycle, and the concurrent write is not retained.

Source files
------------

// File: rtl/regfile_pipelined.sv
// regfile_pipelined: two registered read ports, one bypassed write port, pending-write scoreboard
module regfile_pipelined #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  readEn,
  input  logic [ADDR_W-1:0]     readReg1,
  input  logic [ADDR_W-1:0]     readReg2,
  output logic [DATA_W-1:0]     readData1,
  output logic [DATA_W-1:0]     readData2,
  output logic                  readValid,
  output logic                  busy1,
  output logic                  busy2,
  input  logic                  regWrite,
  input  logic [ADDR_W-1:0]     writeReg,
  input  logic [DATA_W-1:0]     writeData,
  input  logic                  claimEn,
  input  logic [ADDR_W-1:0]     claimReg,
  output logic [(1<<ADDR_W)-1:0] pendingMask
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam bit ZR = ZERO_REG != 0;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d, pend_w, wr_hot, cl_hot;
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d;
  logic busy1_q, busy1_d, busy2_q, busy2_d, valid_q;
  logic wr_ok, cl_ok;
  assign wr_ok = regWrite && !(ZR && writeReg == '0);
  assign cl_ok = claimEn && !(ZR && claimReg == '0);
  // busy reflects the write clear but not a same-edge claim
  always_comb begin
    wr_hot = '0;
    cl_hot = '0;
    wr_hot[writeReg] = wr_ok;
    cl_hot[claimReg] = cl_ok;
    pend_w = pend_q & ~wr_hot;
    pend_d = pend_w | cl_hot;
    rd1_d = (ZR && readReg1 == '0) ? '0 : (wr_ok && writeReg == readReg1) ? writeData : mem_q[readReg1];
    rd2_d = (ZR && readReg2 == '0) ? '0 : (wr_ok && writeReg == readReg2) ? writeData : mem_q[readReg2];
    busy1_d = pend_w[readReg1];
    busy2_d = pend_w[readReg2];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[writeReg] <= writeData;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q  <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      busy1_q <= 1'b0;
      busy2_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= readEn;
      if (readEn) begin
        rd1_q   <= rd1_d;
        rd2_q   <= rd2_d;
        busy1_q <= busy1_d;
        busy2_q <= busy2_d;
      end
    end
  end
  assign readData1   = rd1_q;
  assign readData2   = rd2_q;
  assign busy1       = busy1_q;
  assign busy2       = busy2_q;
  assign readValid   = valid_q;
  assign pendingMask = pend_q;
endmodule

// File: tb/tb_regfile_pipelined.sv
// tb_regfile_pipelined: scoreboard bench for regfile_pipelined (ZERO_REG=1 modelled, ZERO_REG=0 spot-checked)
module tb_regfile_pipelined;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = 1 << AW;
  logic clk = 1'b0;
  logic rst, re, we, ce;
  logic [AW-1:0] r1, r2, wa, ca;
  logic [DW-1:0] wd;
  logic [DW-1:0] rd1, rd2, zd1, zd2;
  logic rv, b1, b2, zv, zb1, zb2;
  logic [D-1:0] pm, zpm;
  logic [DW-1:0] m [D];
  logic [D-1:0] p;
  logic [2*DW+1:0] q [$];
  logic [2*DW+1:0] held, e;
  logic exp_v;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  regfile_pipelined #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dut (
    .clk(clk), .reset(rst), .readEn(re), .readReg1(r1), .readReg2(r2),
    .readData1(rd1), .readData2(rd2), .readValid(rv), .busy1(b1), .busy2(b2),
    .regWrite(we), .writeReg(wa), .writeData(wd), .claimEn(ce), .claimReg(ca),
    .pendingMask(pm));
  regfile_pipelined #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut0 (
    .clk(clk), .reset(rst), .readEn(re), .readReg1(r1), .readReg2(r2),
    .readData1(zd1), .readData2(zd2), .readValid(zv), .busy1(zb1), .busy2(zb2),
    .regWrite(we), .writeReg(wa), .writeData(wd), .claimEn(ce), .claimReg(ca),
    .pendingMask(zpm));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic idle();
    rst = 0; re = 0; we = 0; ce = 0; r1 = 0; r2 = 0; wa = 0; ca = 0; wd = 0;
  endtask
  // advance one edge, update the reference model, then compare
  task automatic cycle();
    logic [D-1:0] pw;
    logic wok;
    logic [DW-1:0] e1, e2;
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < D; i++) m[i] = '0;
      p = '0; exp_v = 0; held = '0; q.delete();
    end else begin
      wok = we && wa != 0;
      pw = p;
      if (wok) pw[wa] = 1'b0;
      e1 = (r1 == 0) ? '0 : (wok && wa == r1) ? wd : m[r1];
      e2 = (r2 == 0) ? '0 : (wok && wa == r2) ? wd : m[r2];
      exp_v = re;
      if (re) q.push_back({e1, e2, pw[r1], pw[r2]});
      if (wok) m[wa] = wd;
      p = pw;
      if (ce && ca != 0) p[ca] = 1'b1;
    end
    #1;
    chk("readValid", 64'(rv), 64'(exp_v));
    chk("pendingMask", 64'(pm), 64'(p));
    if (exp_v && q.size() > 0) begin
      e = q.pop_front();
      held = e;
    end
    chk("readData1", 64'(rd1), 64'(held[2*DW+1:DW+2]));
    chk("readData2", 64'(rd2), 64'(held[DW+1:2]));
    chk("busy1", 64'(b1), 64'(held[1]));
    chk("busy2", 64'(b2), 64'(held[0]));
  endtask
  initial begin
    idle(); rst = 1; held = '0; exp_v = 0; p = '0;
    cycle();
    idle(); re = 1; r1 = 3; r2 = 7; cycle();
    idle(); cycle();
    idle(); we = 1; wa = 5; wd = 32'hDEADBEEF; cycle();
    idle(); re = 1; r1 = 5; r2 = 0; cycle();
    chk("x5_read", 64'(rd1), 64'h0DEADBEEF);
    idle(); cycle();
    idle(); we = 1; wa = 9; wd = 32'h1234; re = 1; r1 = 9; r2 = 9; cycle();
    chk("bypass_both", 64'({rd1, rd2}), {32'h1234, 32'h1234});
    idle(); we = 1; wa = 0; wd = 32'hFFFFFFFF; ce = 1; ca = 0; cycle();
    chk("z1_mask0", 64'(pm[0]), 64'd0);
    chk("z0_mask0", 64'(zpm[0]), 64'd1);
    idle(); re = 1; r1 = 0; cycle();
    chk("z1_x0", 64'(rd1), 64'd0);
    chk("z0_x0", 64'(zd1), 64'hFFFFFFFF);
    chk("z0_busy", 64'(zb1), 64'd1);
    idle(); ce = 1; ca = 4; cycle();
    chk("claim4", 64'(pm[4]), 64'd1);
    idle(); re = 1; r2 = 4; cycle();
    chk("busy2_set", 64'(b2), 64'd1);
    idle(); we = 1; wa = 4; wd = 32'hAAAA; re = 1; r2 = 4; cycle();
    chk("busy2_clr", 64'(b2), 64'd0);
    idle(); we = 1; wa = 4; wd = 32'h5555; ce = 1; ca = 4; cycle();
    chk("claim_wins", 64'(pm[4]), 64'd1);
    idle(); re = 1; r1 = 4; cycle();
    chk("x4_new", 64'(rd1), 64'h5555);
    for (int n = 0; n < 300; n++) begin
      idle();
      rst = ($urandom_range(0, 59) == 0);
      re = $urandom_range(0, 1); we = $urandom_range(0, 1); ce = $urandom_range(0, 2) == 0;
      r1 = AW'($urandom_range(0, 11)); r2 = AW'($urandom_range(0, 11));
      wa = AW'($urandom_range(0, 11)); ca = AW'($urandom_range(0, 11));
      wd = $urandom;
      cycle();
    end
    idle(); we = 1; wa = 6; wd = 32'h66; ce = 1; ca = 7; cycle();
    idle(); rst = 1; we = 1; wa = 10; wd = 32'hCAFE; ce = 1; ca = 11; re = 1; r1 = 6; cycle();
    chk("rst_mask", 64'(pm), 64'd0);
    idle(); re = 1; r1 = 10; r2 = 6; cycle();
    chk("rst_drop_wr", 64'({rd1, rd2}), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
